// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream, using two line buffers.
// A window is emitted one cycle after each accept whose pixel sits at row>=2, col>=2.
module conv_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic signed [7:0] pix_i,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  output logic signed [7:0] k_0,
  output logic signed [7:0] k_1,
  output logic signed [7:0] k_2,
  output logic signed [7:0] k_3,
  output logic signed [7:0] k_4,
  output logic signed [7:0] k_5,
  output logic signed [7:0] k_6,
  output logic signed [7:0] k_7,
  output logic signed [7:0] k_8,
  output logic              win_valid_o,
  input  logic              win_ready_i,
  output logic              frame_done_o
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    lb0 [IMG_W];
  logic [7:0]    lb1 [IMG_W];
  logic [8:0][7:0] win;
  logic [2:0][7:0] new_col;
  logic accept, last_col, last_row, win_hit, xfer;

  assign pix_ready_o = !win_valid_o | win_ready_i;
  assign accept      = pix_valid_i & pix_ready_o;
  assign xfer        = win_valid_o & win_ready_i;
  assign last_col    = (col == COL_MAX);
  assign last_row    = (row == ROW_MAX);
  assign win_hit     = accept && (row >= RW'(2)) && (col >= CW'(2));
  // right-hand column entering the window: oldest row first
  assign new_col     = {pix_i, lb0[col], lb1[col]};

  assign k_0 = win[0]; assign k_1 = win[1]; assign k_2 = win[2];
  assign k_3 = win[3]; assign k_4 = win[4]; assign k_5 = win[5];
  assign k_6 = win[6]; assign k_7 = win[7]; assign k_8 = win[8];

  // line buffers carry no reset; stale rows never reach a valid window
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pix_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      col          <= '0;
      row          <= '0;
      win          <= '0;
      win_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= accept && last_col && last_row;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[3*r]   <= win[3*r+1];
          win[3*r+1] <= win[3*r+2];
          win[3*r+2] <= new_col[r];
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (win_hit)   win_valid_o <= 1'b1;
      else if (xfer) win_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: a frame-image model predicts each window,
// a monitor checks windows, latency, stall stability and handshake rules.
module tb_conv_window_gen;
  localparam int W = 4;
  localparam int H = 4;

  logic              clk_i = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [7:0] pix_i = '0;
  logic              pix_valid_i = 1'b0;
  logic              win_ready_i = 1'b1;
  logic              pix_ready_o, win_valid_o, frame_done_o;
  logic signed [7:0] k_0, k_1, k_2, k_3, k_4, k_5, k_6, k_7, k_8;

  conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .pix_i(pix_i), .pix_valid_i(pix_valid_i),
    .pix_ready_o(pix_ready_o), .k_0(k_0), .k_1(k_1), .k_2(k_2), .k_3(k_3),
    .k_4(k_4), .k_5(k_5), .k_6(k_6), .k_7(k_7), .k_8(k_8),
    .win_valid_o(win_valid_o), .win_ready_i(win_ready_i), .frame_done_o(frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { logic [71:0] win; int cyc; } exp_t;
  exp_t exp_q[$];

  logic [71:0] dut_win;
  assign dut_win = {k_0, k_1, k_2, k_3, k_4, k_5, k_6, k_7, k_8};

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: remembers the whole frame image and cuts windows out of it.
  int mr = 0, mc = 0;
  logic fd_pend = 1'b0;
  logic signed [7:0] img [H][W];
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_n) begin
      mr = 0; mc = 0; fd_pend = 1'b0;
      exp_q.delete();
    end else begin
      chk("frame_done", 72'(frame_done_o), 72'(fd_pend));
      fd_pend = 1'b0;
      if (pix_valid_i && pix_ready_o) begin
        img[mr][mc] = pix_i;
        if (mr >= 2 && mc >= 2) begin
          e.win = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                   img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                   img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
          e.cyc = cyc + 1;
          exp_q.push_back(e);
        end
        fd_pend = (mr == H-1 && mc == W-1);
        if (mc == W-1) begin
          mc = 0;
          mr = (mr == H-1) ? 0 : mr + 1;
        end else begin
          mc++;
        end
      end
    end
  end

  // Monitor
  logic hold_prev = 1'b0;
  logic [71:0] hold_win = '0;
  always @(negedge clk_i) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
      chk("rst_win_valid", 72'(win_valid_o), 72'(0));
      chk("rst_frame_done", 72'(frame_done_o), 72'(0));
      chk("rst_window", dut_win, 72'(0));
      chk("rst_pix_ready", 72'(pix_ready_o), 72'(1));
    end else begin
      chk("pix_ready", 72'(pix_ready_o), 72'(!win_valid_o || win_ready_i));
      if (hold_prev) begin
        chk("hold_valid", 72'(win_valid_o), 72'(1));
        chk("hold_window", dut_win, hold_win);
      end
      if (win_valid_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_window: got %h expected none (cycle %0d)", dut_win, cyc);
          hold_prev = 1'b0;
        end else begin
          if (!hold_prev) chk("win_latency", 72'(cyc), 72'(exp_q[0].cyc));
          if (win_ready_i) begin
            chk("win_data", dut_win, exp_q[0].win);
            void'(exp_q.pop_front());
            hold_prev = 1'b0;
          end else begin
            hold_prev = 1'b1;
            hold_win  = dut_win;
          end
        end
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  // Driver
  logic signed [7:0] pq[$];

  task automatic load(input int base);
    for (int i = 0; i < W*H; i++) pq.push_back(8'(base + i));
  endtask

  // vmode: 0 always valid, 1 every other cycle, 2 random
  // rmode: 0 always ready, 1 random, 2 hold first window 5 cycles
  task automatic run(input int vmode, input int rmode);
    int guard = 0;
    int stall = 0;
    logic acc;
    while (pq.size() > 0 && guard < 2000) begin
      pix_i       = pq[0];
      pix_valid_i = (vmode == 0) ? 1'b1 : (vmode == 1) ? (guard % 2 == 0)
                                        : ($urandom_range(9) < 7);
      win_ready_i = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(9) < 6)
                                        : (stall >= 5);
      @(negedge clk_i);
      if (rmode == 2 && win_valid_o && !win_ready_i) stall++;
      acc = pix_valid_i && pix_ready_o;
      @(posedge clk_i); #1;
      if (acc) void'(pq.pop_front());
      guard++;
    end
    if (guard >= 2000) begin
      n_cmp++; n_err++;
      $display("FAIL stream_timeout: got %0d pixels left expected 0", pq.size());
      pq.delete();
    end
    pix_valid_i = 1'b0;
  endtask

  task automatic drain();
    pix_valid_i = 1'b0;
    win_ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    chk("drain_empty", 72'(exp_q.size()), 72'(0));
  endtask

  initial begin
    logic signed [7:0] v;
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;

    load(0); run(0, 0); drain();             // plain 4x4 frame
    load(0); run(0, 2); drain();             // downstream stall on first window
    for (int i = 0; i < W*H; i++) begin      // sign extremes
      case ($urandom_range(2))
        0:       v = -8'sd128;
        1:       v = -8'sd1;
        default: v = 8'sd127;
      endcase
      pq.push_back(v);
    end
    run(0, 0); drain();
    load(0); load(100); run(0, 0); drain();  // back-to-back frames

    for (int i = 0; i < 10; i++) pq.push_back(8'(i));   // reset mid-frame
    run(0, 0);
    rst_n = 1'b0;
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    load(0); run(0, 0); drain();

    load(0); run(1, 0); drain();             // valid toggling
    for (int f = 0; f < 6; f++)
      for (int i = 0; i < W*H; i++) pq.push_back(8'($urandom_range(255)));
    run(2, 1); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
